control_sequencer: RTL

Microcoded control sequencer for the 8-bit CPU; sits directly upstream of the datapath (PC, MAR/RAM, IR, accumulator, ALU, B and output registers) and drives the 15-bit control word. A six-phase T-state counter runs fetch (T0–T2) and execute (T3–T5). Each phase is decoded from the IR opcode and the ALU flags.

---
 rtl/control_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: six-phase microcoded control unit for the 8-bit CPU.
// Drives the 15-bit control word from the T-state, the IR opcode and the ALU flags.
module control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        CF,
  input  logic        ZF,
  output logic [14:0] control_signals,
  output logic [2:0]  t_state,
  output logic        halted
);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    HALT = 3'd6
  } state_t;

  // Bit positions in the control word
  localparam int B_CP   = 14;
  localparam int B_EP   = 13;
  localparam int B_LP   = 12;
  localparam int B_NLMA = 11;
  localparam int B_NLMD = 10;
  localparam int B_NCE  = 9;
  localparam int B_NLR  = 8;
  localparam int B_NLI  = 7;
  localparam int B_NEI  = 6;
  localparam int B_NLA  = 5;
  localparam int B_EA   = 4;
  localparam int B_SUB  = 3;
  localparam int B_EU   = 2;
  localparam int B_NLB  = 1;
  localparam int B_NLO  = 0;

  // Every active-high line low, every active-low line high
  localparam logic [14:0] IDLE = 15'h0FE3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t      state;
  state_t      next_state;
  logic [14:0] cw;

  // Phase register; reset drops straight back to the start of fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= T0;
    end else begin
      state <= next_state;
    end
  end

  // Phase sequencing and control-word decode; lines not driven by a phase stay idle
  always_comb begin
    next_state = state;
    cw         = IDLE;
    case (state)
      T0: begin
        cw[B_EP]   = 1'b1;
        cw[B_NLMA] = 1'b0;
        next_state = T1;
      end
      T1: begin
        cw[B_CP]   = 1'b1;
        next_state = T2;
      end
      T2: begin
        cw[B_NCE]  = 1'b0;
        cw[B_NLI]  = 1'b0;
        next_state = T3;
      end
      T3: begin
        next_state = T4;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[B_NEI]  = 1'b0;
            cw[B_NLMA] = 1'b0;
          end
          OP_LDI: begin
            cw[B_NEI] = 1'b0;
            cw[B_NLA] = 1'b0;
          end
          OP_JMP: begin
            cw[B_NEI] = 1'b0;
            cw[B_LP]  = 1'b1;
          end
          // Conditional jumps look at the flags here and nowhere else
          OP_JC: begin
            if (CF) begin
              cw[B_NEI] = 1'b0;
              cw[B_LP]  = 1'b1;
            end
          end
          OP_JZ: begin
            if (ZF) begin
              cw[B_NEI] = 1'b0;
              cw[B_LP]  = 1'b1;
            end
          end
          OP_OUT: begin
            cw[B_EA]  = 1'b1;
            cw[B_NLO] = 1'b0;
          end
          OP_HLT: begin
            next_state = HALT;
          end
          default: ;
        endcase
      end
      T4: begin
        next_state = T5;
        case (opcode)
          OP_LDA: begin
            cw[B_NCE] = 1'b0;
            cw[B_NLA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            cw[B_NCE] = 1'b0;
            cw[B_NLB] = 1'b0;
          end
          OP_STA: begin
            cw[B_EA]   = 1'b1;
            cw[B_NLMD] = 1'b0;
          end
          default: ;
        endcase
      end
      T5: begin
        next_state = T0;
        case (opcode)
          OP_ADD: begin
            cw[B_EU]  = 1'b1;
            cw[B_NLA] = 1'b0;
          end
          OP_SUB: begin
            cw[B_EU]  = 1'b1;
            cw[B_NLA] = 1'b0;
            cw[B_SUB] = 1'b1;
          end
          OP_STA: begin
            cw[B_NLR] = 1'b0;
          end
          default: ;
        endcase
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = T0;
      end
    endcase
  end

  assign control_signals = cw;
  assign t_state         = (state == HALT) ? 3'd3 : state;
  assign halted          = (state == HALT);

endmodule
